decode38_scan: RTL and testbench

Registered 3-to-8 decoder with active-low outputs and 74138-style enables (G1, G2A_n, G2B_n). It is the output-side counterpart of the 8-to-3 priority encoder.
- Direct mode: a loaded 3-bit code drives one active-low line.
- Scan mode: an internal sequencer walks codes 0..7 with a programmable dwell per line, for driving keyboard or LED matrix rows whose returns feed the encoder.

---
 rtl/decode38_scan_pkg.sv | 22 ++
 rtl/decode38_comb.sv | 32 +++
 rtl/decode38_scan.sv | 162 ++++++++++++++++
 tb/tb_decode38_scan.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/decode38_scan_pkg.sv
// -----------------------------------------------------------------------------
// decode38_scan_pkg
//
// Shared definitions for the registered 3-to-8 decoder / row scanner.
//
// Contents:
//   state_t    - controller state: IDLE, DIRECT, SCAN
//   Y_ALL_OFF  - active-low output word with no line driven
//   CODE_MAX   - highest code value; stepping past it wraps to 0
// -----------------------------------------------------------------------------
package decode38_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [7:0] Y_ALL_OFF = 8'hFF;
    localparam logic [2:0] CODE_MAX  = 3'd7;

endpackage : decode38_scan_pkg

// File: rtl/decode38_comb.sv
// -----------------------------------------------------------------------------
// decode38_comb
//
// Pure combinational 3-to-8 decoder with active-low one-hot output. This is
// the exact inverse mapping of the 8-to-3 priority encoder: y[i] is low only
// when valid is high and code equals i. It can be used on its own.
//
// Ports:
//   code  [2:0] in   code to decode, bit 2 is the MSB
//   valid       in   drive a line when high; all lines off when low
//   y     [7:0] out  active-low decoded lines, at most one bit low
// -----------------------------------------------------------------------------
module decode38_comb
    import decode38_scan_pkg::*;
(
    input  logic [2:0] code,
    input  logic       valid,
    output logic [7:0] y
);

    always_comb begin
        // NOTE: assigning a default before any conditional logic means every
        // path writes y, so no latch is inferred.
        y = Y_ALL_OFF;
        // An unknown valid falls to the default (all lines off) rather than
        // selecting a line, so an X never turns into a low output.
        if (valid) begin
            y = ~(8'b0000_0001 << code);
        end
    end

endmodule : decode38_comb

// File: rtl/decode38_scan.sv
// -----------------------------------------------------------------------------
// decode38_scan
//
// Registered 3-to-8 decoder with active-low outputs and 74138-style enables.
// Two operating modes:
//   direct - a 3-bit code captured on load drives a single active-low line;
//   scan   - an internal sequencer walks codes 0..7, holding each one for
//            DWELL clock cycles, for driving keyboard or LED matrix rows.
// All outputs are registered; Y follows code_q/valid with no extra latency.
//
// Parameters:
//   DWELL    cycles each code is held in scan mode (0 behaves as 1)
//   DWELL_W  width of the dwell counter; DWELL must fit in DWELL_W bits
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   G1           in   enable, active-high
//   G2A_n        in   enable, active-low
//   G2B_n        in   enable, active-low
//   mode         in   0 = direct, 1 = scan
//   load         in   direct mode: capture {C,B,A} this cycle
//   C, B, A      in   code bits 2..0
//   hold         in   scan mode: freeze code and dwell counter
//   Y      [7:0] out  active-low decoded lines
//   code_q [2:0] out  currently driven code
//   valid        out  high while a line is being driven
//   wrap         out  one-cycle pulse when scan steps from code 7 to code 0
// -----------------------------------------------------------------------------
module decode38_scan
    import decode38_scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 8
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       G1,
    input  logic       G2A_n,
    input  logic       G2B_n,
    input  logic       mode,
    input  logic       load,
    input  logic       C,
    input  logic       B,
    input  logic       A,
    input  logic       hold,
    output logic [7:0] Y,
    output logic [2:0] code_q,
    output logic       valid,
    output logic       wrap
);

    // A dwell of zero is meaningless; treat it as one cycle per code.
    localparam int                 DWELL_EFF  = (DWELL < 1) ? 1 : DWELL;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_EFF - 1);

    state_t             state_q;
    state_t             state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [2:0]         code_d;
    logic               valid_d;
    logic               wrap_d;
    logic [7:0]         y_d;
    logic               en;

    assign en = G1 & ~G2A_n & ~G2B_n;

    // -------------------------------------------------------------------------
    // Next-state, next-code and next-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;

        // Enable is tested in the positive sense so that an unknown enable
        // takes the disabled branch and leaves every line off.
        if (en) begin
            unique case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        // Entering scan always restarts from code 0.
                        state_d = SCAN;
                        code_d  = 3'd0;
                        valid_d = 1'b1;
                        dwell_d = '0;
                    end else if (load) begin
                        state_d = DIRECT;
                        code_d  = {C, B, A};
                        valid_d = 1'b1;
                    end
                end

                SCAN: begin
                    if (!mode) begin
                        // Leaving scan goes through IDLE; a load in the same
                        // cycle is deliberately dropped.
                        state_d = IDLE;
                        valid_d = 1'b0;
                        dwell_d = '0;
                    end else if (!hold) begin
                        if (dwell_q >= DWELL_LAST) begin
                            dwell_d = '0;
                            code_d  = code_q + 3'd1;
                            wrap_d  = (code_q == CODE_MAX);
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    dwell_d = '0;
                end
            endcase
        end else begin
            // Disabled: lines off, code retained for observation only. The
            // next scan entry resets the code, so the retained value never
            // resumes a scan.
            state_d = IDLE;
            valid_d = 1'b0;
            dwell_d = '0;
        end
    end

    // Decode the next code so Y is registered in step with code_q/valid.
    decode38_comb u_decode (
        .code  (code_d),
        .valid (valid_d),
        .y     (y_d)
    );

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            code_q  <= 3'd0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            Y       <= Y_ALL_OFF;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            code_q  <= code_d;
            valid   <= valid_d;
            wrap    <= wrap_d;
            Y       <= y_d;
        end
    end

endmodule : decode38_scan

// File: tb/tb_decode38_scan.sv
// -----------------------------------------------------------------------------
// tb_decode38_scan
//
// Self-checking bench for decode38_scan. A DWELL=4 instance covers reset,
// direct mode, a full scan, hold and mid-scan reset; a DWELL=1 instance
// sharing the same inputs covers fast scan and enable drop/restore.
// -----------------------------------------------------------------------------
module tb_decode38_scan;

    logic       clk = 1'b0;
    logic       rst_n, G1, G2A_n, G2B_n, mode, load, C, B, A, hold;
    logic [7:0] y4, y1;
    logic [2:0] code4, code1;
    logic       valid4, valid1, wrap4, wrap1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode38_scan #(.DWELL(4), .DWELL_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .G1(G1), .G2A_n(G2A_n), .G2B_n(G2B_n),
        .mode(mode), .load(load), .C(C), .B(B), .A(A), .hold(hold),
        .Y(y4), .code_q(code4), .valid(valid4), .wrap(wrap4)
    );

    decode38_scan #(.DWELL(1), .DWELL_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .G1(G1), .G2A_n(G2A_n), .G2B_n(G2B_n),
        .mode(mode), .load(load), .C(C), .B(B), .A(A), .hold(hold),
        .Y(y1), .code_q(code1), .valid(valid1), .wrap(wrap1)
    );

    typedef struct {
        logic       rst_n, g1, g2a_n, g2b_n, mode, load;
        logic [2:0] cba;
        logic       hold;
        logic [7:0] y;
        logic [2:0] code;
        logic       valid, wrap;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] ylut[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [7:0] y, input logic [2:0] code,
                          input logic valid, input logic wrap);
        check({name, ".Y"},     y4,            y);
        check({name, ".code"},  {5'd0, code4}, {5'd0, code});
        check({name, ".valid"}, {7'd0, valid4}, {7'd0, valid});
        check({name, ".wrap"},  {7'd0, wrap4},  {7'd0, wrap});
    endtask

    task automatic check1(input string name, input logic [7:0] y, input logic [2:0] code,
                          input logic valid, input logic wrap);
        check({name, ".Y"},     y1,             y);
        check({name, ".code"},  {5'd0, code1},  {5'd0, code});
        check({name, ".valid"}, {7'd0, valid1}, {7'd0, valid});
        check({name, ".wrap"},  {7'd0, wrap1},  {7'd0, wrap});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; G1 = v.g1; G2A_n = v.g2a_n; G2B_n = v.g2b_n;
        mode = v.mode; load = v.load; {C, B, A} = v.cba; hold = v.hold;
    endtask

    initial begin
        int wraps;
        int exp_code;

        ylut = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        //            rst  g1   g2a  g2b  mode load cba   hold  Y      code  vld  wrap
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,3'd5,1'b1, 8'hFF, 3'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,3'd5,1'b0, 8'hFF, 3'd0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,3'd5,1'b0, 8'hFF, 3'd0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,3'd3,1'b0, 8'hFF, 3'd0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd6,1'b0, 8'hFF, 3'd0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'd5,1'b0, 8'hDF, 3'd5,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b0, 8'hDF, 3'd5,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'd0,1'b0, 8'hFE, 3'd0,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'd7,1'b0, 8'h7F, 3'd7,1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,3'd3,1'b0, 8'hFF, 3'd7,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd3,1'b0, 8'hFF, 3'd7,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'd3,1'b0, 8'hF7, 3'd3,1'b1,1'b0};

        rst_n = 1'b0; G1 = 1'b0; G2A_n = 1'b1; G2B_n = 1'b1;
        mode = 1'b0; load = 1'b0; {C, B, A} = 3'd0; hold = 1'b0;

        // Reset, enable gating and direct mode.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            step();
            check4($sformatf("vec%0d", i), vecs[i].y, vecs[i].code, vecs[i].valid, vecs[i].wrap);
        end

        // Full scan from DIRECT, DWELL=4, 40 cycles: one wrap at cycle 32.
        mode = 1'b1; load = 1'b0; hold = 1'b0;
        wraps = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            exp_code = (k / 4) % 8;
            if (wrap4) wraps++;
            check4($sformatf("scan4_%0d", k), ylut[exp_code], 3'(exp_code), 1'b1, (k == 32));
        end
        check("scan4_wrap_count", 8'(wraps), 8'd1);

        // Mode drops with a simultaneous load: load ignored, lines off.
        mode = 1'b0; load = 1'b1; {C, B, A} = 3'd6;
        step();
        check4("scan_exit", 8'hFF, 3'd1, 1'b0, 1'b0);

        // Hold for 3 cycles while code 2 is showing: code 2 lasts 7 cycles.
        load = 1'b0; mode = 1'b1;
        for (int j = 0; j < 20; j++) begin
            hold = (j >= 9 && j <= 11);
            step();
            if (j < 8)       exp_code = j / 4;
            else if (j < 15) exp_code = 2;
            else             exp_code = 3 + (j - 15) / 4;
            check4($sformatf("hold_%0d", j), ylut[exp_code], 3'(exp_code), 1'b1, 1'b0);
        end
        hold = 1'b0;

        // Reset in the middle of a scan.
        rst_n = 1'b0;
        step();
        check4("mid_reset4", 8'hFF, 3'd0, 1'b0, 1'b0);
        check1("mid_reset1", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // DWELL=1: new code every cycle, wrap at the 7->0 step, stop at code 6.
        for (int j = 0; j < 15; j++) begin
            step();
            check1($sformatf("scan1_%0d", j), ylut[j % 8], 3'(j % 8), 1'b1, (j == 8));
        end

        // Drop G1 at code 6: lines off, code retained.
        G1 = 1'b0;
        for (int j = 0; j < 2; j++) begin
            step();
            check1($sformatf("g1_off_%0d", j), 8'hFF, 3'd6, 1'b0, 1'b0);
        end

        // Restore G1: scan restarts at code 0.
        G1 = 1'b1;
        step();
        check1("g1_restore", 8'hFE, 3'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_decode38_scan
